// File: rtl/idex_stage.sv
// ---------------------------------------------------------------------------
// idex_stage -- ID/EX pipeline register with forwarding-code generation,
// load-use hazard detection and a saturating bubble counter.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   stall               : global freeze, every register holds
//   flush               : squash the instruction currently in ID
//   id_*                : decoded instruction fields from ID
//   exmem_regwrite/_rd  : destination of the instruction in EX/MEM
//   ex_*                : registered copies of the id_* fields, plus ex_valid
//   forwardA/B          : 3'b010 selects the EX/MEM ALU result
//   MEMforwardA/B       : 3'b001 selects the MEM/WB write data
//   hazard_stall        : combinational load-use stall request to PC and IF/ID
//   stall_count         : saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module idex_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [4:0]    id_rs,
   input  logic [4:0]    id_rt,
   input  logic [4:0]    id_rd,
   input  logic [DW-1:0] id_rsdata,
   input  logic [DW-1:0] id_rtdata,
   input  logic [DW-1:0] id_imm,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_memtoreg,
   input  logic          id_alusrc,
   input  logic [3:0]    id_aluop,
   input  logic          exmem_regwrite,
   input  logic [4:0]    exmem_rd,
   output logic          ex_valid,
   output logic [4:0]    ex_rs,
   output logic [4:0]    ex_rt,
   output logic [4:0]    ex_rd,
   output logic [DW-1:0] ex_rsdata,
   output logic [DW-1:0] ex_rtdata,
   output logic [DW-1:0] ex_imm,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_memtoreg,
   output logic          ex_alusrc,
   output logic [3:0]    ex_aluop,
   output logic [2:0]    forwardA,
   output logic [2:0]    forwardB,
   output logic [2:0]    MEMforwardA,
   output logic [2:0]    MEMforwardB,
   output logic          hazard_stall,
   output logic [CW-1:0] stall_count
);

   localparam logic [2:0] FWD_NONE = 3'b000;
   localparam logic [2:0] FWD_MEM  = 3'b001;
   localparam logic [2:0] FWD_EX   = 3'b010;

   logic          ex_valid_q,    ex_valid_d;
   logic [4:0]    ex_rs_q,       ex_rs_d;
   logic [4:0]    ex_rt_q,       ex_rt_d;
   logic [4:0]    ex_rd_q,       ex_rd_d;
   logic [DW-1:0] ex_rsdata_q,   ex_rsdata_d;
   logic [DW-1:0] ex_rtdata_q,   ex_rtdata_d;
   logic [DW-1:0] ex_imm_q,      ex_imm_d;
   logic          ex_regwrite_q, ex_regwrite_d;
   logic          ex_memread_q,  ex_memread_d;
   logic          ex_memwrite_q, ex_memwrite_d;
   logic          ex_memtoreg_q, ex_memtoreg_d;
   logic          ex_alusrc_q,   ex_alusrc_d;
   logic [3:0]    ex_aluop_q,    ex_aluop_d;
   logic [2:0]    fwd_a_q,       fwd_a_d;
   logic [2:0]    fwd_b_q,       fwd_b_d;
   logic [2:0]    mem_fwd_a_q,   mem_fwd_a_d;
   logic [2:0]    mem_fwd_b_q,   mem_fwd_b_d;
   logic [CW-1:0] stall_count_q, stall_count_d;

   logic hazard;
   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

   // The instruction now in EX is the one that will sit in EX/MEM while the
   // ID instruction executes, so it is the newest producer.
   assign ex_hit_rs  = ex_valid_q & ex_regwrite_q & (ex_rd_q != 5'd0) & (ex_rd_q == id_rs);
   assign ex_hit_rt  = ex_valid_q & ex_regwrite_q & (ex_rd_q != 5'd0) & (ex_rd_q == id_rt);
   assign mem_hit_rs = exmem_regwrite & (exmem_rd != 5'd0) & (exmem_rd == id_rs);
   assign mem_hit_rt = exmem_regwrite & (exmem_rd != 5'd0) & (exmem_rd == id_rt);

   assign hazard = ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) &
                   ((ex_rd_q == id_rs) | (ex_rd_q == id_rt)) & id_valid;

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_rs_d       = ex_rs_q;
      ex_rt_d       = ex_rt_q;
      ex_rd_d       = ex_rd_q;
      ex_rsdata_d   = ex_rsdata_q;
      ex_rtdata_d   = ex_rtdata_q;
      ex_imm_d      = ex_imm_q;
      ex_regwrite_d = ex_regwrite_q;
      ex_memread_d  = ex_memread_q;
      ex_memwrite_d = ex_memwrite_q;
      ex_memtoreg_d = ex_memtoreg_q;
      ex_alusrc_d   = ex_alusrc_q;
      ex_aluop_d    = ex_aluop_q;
      fwd_a_d       = fwd_a_q;
      fwd_b_d       = fwd_b_q;
      mem_fwd_a_d   = mem_fwd_a_q;
      mem_fwd_b_d   = mem_fwd_b_q;
      stall_count_d = stall_count_q;

      if (!stall) begin
         // Data fields are captured even for a bubble; they are don't-care
         // once ex_valid and the control bits are cleared.
         ex_rs_d     = id_rs;
         ex_rt_d     = id_rt;
         ex_rd_d     = id_rd;
         ex_rsdata_d = id_rsdata;
         ex_rtdata_d = id_rtdata;
         ex_imm_d    = id_imm;

         if (flush || hazard) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memwrite_d = 1'b0;
            ex_memtoreg_d = 1'b0;
            ex_alusrc_d   = 1'b0;
            ex_aluop_d    = '0;
            fwd_a_d       = FWD_NONE;
            fwd_b_d       = FWD_NONE;
            mem_fwd_a_d   = FWD_NONE;
            mem_fwd_b_d   = FWD_NONE;
            // Only load-use bubbles are counted; a flush absorbs a
            // coincident hazard into the same single bubble.
            if (hazard && !flush && (stall_count_q != '1)) begin
               stall_count_d = stall_count_q + 1'b1;
            end
         end else begin
            ex_valid_d    = id_valid;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
            ex_memwrite_d = id_memwrite;
            ex_memtoreg_d = id_memtoreg;
            ex_alusrc_d   = id_alusrc;
            ex_aluop_d    = id_aluop;
            fwd_a_d       = ex_hit_rs ? FWD_EX : FWD_NONE;
            fwd_b_d       = ex_hit_rt ? FWD_EX : FWD_NONE;
            mem_fwd_a_d   = (mem_hit_rs && !ex_hit_rs) ? FWD_MEM : FWD_NONE;
            mem_fwd_b_d   = (mem_hit_rt && !ex_hit_rt) ? FWD_MEM : FWD_NONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         ex_rd_q       <= '0;
         ex_rsdata_q   <= '0;
         ex_rtdata_q   <= '0;
         ex_imm_q      <= '0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_memwrite_q <= 1'b0;
         ex_memtoreg_q <= 1'b0;
         ex_alusrc_q   <= 1'b0;
         ex_aluop_q    <= '0;
         fwd_a_q       <= FWD_NONE;
         fwd_b_q       <= FWD_NONE;
         mem_fwd_a_q   <= FWD_NONE;
         mem_fwd_b_q   <= FWD_NONE;
         stall_count_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         ex_rd_q       <= ex_rd_d;
         ex_rsdata_q   <= ex_rsdata_d;
         ex_rtdata_q   <= ex_rtdata_d;
         ex_imm_q      <= ex_imm_d;
         ex_regwrite_q <= ex_regwrite_d;
         ex_memread_q  <= ex_memread_d;
         ex_memwrite_q <= ex_memwrite_d;
         ex_memtoreg_q <= ex_memtoreg_d;
         ex_alusrc_q   <= ex_alusrc_d;
         ex_aluop_q    <= ex_aluop_d;
         fwd_a_q       <= fwd_a_d;
         fwd_b_q       <= fwd_b_d;
         mem_fwd_a_q   <= mem_fwd_a_d;
         mem_fwd_b_q   <= mem_fwd_b_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_rs        = ex_rs_q;
   assign ex_rt        = ex_rt_q;
   assign ex_rd        = ex_rd_q;
   assign ex_rsdata    = ex_rsdata_q;
   assign ex_rtdata    = ex_rtdata_q;
   assign ex_imm       = ex_imm_q;
   assign ex_regwrite  = ex_regwrite_q;
   assign ex_memread   = ex_memread_q;
   assign ex_memwrite  = ex_memwrite_q;
   assign ex_memtoreg  = ex_memtoreg_q;
   assign ex_alusrc    = ex_alusrc_q;
   assign ex_aluop     = ex_aluop_q;
   assign forwardA     = fwd_a_q;
   assign forwardB     = fwd_b_q;
   assign MEMforwardA  = mem_fwd_a_q;
   assign MEMforwardB  = mem_fwd_b_q;
   assign hazard_stall = hazard;
   assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_idex_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_stage -- self-checking bench for idex_stage.
// A behavioural model of the EX-stage contents is compared against the DUT on
// every falling edge; directed instruction sequences add literal checks.
// The counter width is reduced to 4 bits so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_idex_stage;

   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst, stall, flush, id_valid;
   logic [4:0]    id_rs, id_rt, id_rd, exmem_rd;
   logic [DW-1:0] id_rsdata, id_rtdata, id_imm;
   logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
   logic [3:0]    id_aluop;
   logic          exmem_regwrite;

   logic          ex_valid;
   logic [4:0]    ex_rs, ex_rt, ex_rd;
   logic [DW-1:0] ex_rsdata, ex_rtdata, ex_imm;
   logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
   logic [3:0]    ex_aluop;
   logic [2:0]    forwardA, forwardB, MEMforwardA, MEMforwardB;
   logic          hazard_stall;
   logic [CW-1:0] stall_count;

   idex_stage #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_imm(id_imm),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_rsdata(ex_rsdata), .ex_rtdata(ex_rtdata), .ex_imm(ex_imm),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .forwardA(forwardA), .forwardB(forwardB),
      .MEMforwardA(MEMforwardA), .MEMforwardB(MEMforwardB),
      .hazard_stall(hazard_stall), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Contents of one pipeline slot as the specification describes it.
   typedef struct packed {
      bit          valid, regwrite, memread, memwrite, memtoreg, alusrc;
      bit [3:0]    aluop;
      bit [4:0]    rs, rt, rd;
      bit [DW-1:0] rsd, rtd, imm;
      bit [2:0]    fa, fb, mfa, mfb;
      bit          dc;     // data fields are don't-care (bubble)
   } slot_t;

   slot_t       m;         // expected EX contents
   slot_t       prev;      // what EX held before, i.e. today's EX/MEM
   int unsigned m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit writes(input slot_t s, input logic [4:0] r);
      return s.valid && s.regwrite && (r != 5'd0) && (s.rd == r);
   endfunction

   function automatic bit model_haz();
      return m.valid && m.memread && (m.rd != 5'd0) && id_valid &&
             (m.rd == id_rs || m.rd == id_rt);
   endfunction

   function automatic bit mem_writes(input logic [4:0] r);
      return exmem_regwrite && (r != 5'd0) && (exmem_rd == r);
   endfunction

   function automatic slot_t model_next();
      slot_t n;
      n = '0;
      if (flush || model_haz()) begin
         n.dc = 1'b1;
      end else begin
         n.valid = id_valid;  n.regwrite = id_regwrite; n.memread = id_memread;
         n.memwrite = id_memwrite; n.memtoreg = id_memtoreg; n.alusrc = id_alusrc;
         n.aluop = id_aluop;  n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
         n.rsd = id_rsdata;   n.rtd = id_rtdata; n.imm = id_imm;
         n.fa  = writes(m, id_rs) ? 3'b010 : 3'b000;
         n.fb  = writes(m, id_rt) ? 3'b010 : 3'b000;
         n.mfa = (!writes(m, id_rs) && mem_writes(id_rs)) ? 3'b001 : 3'b000;
         n.mfb = (!writes(m, id_rt) && mem_writes(id_rt)) ? 3'b001 : 3'b000;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m     <= '0;
         prev  <= '0;
         m_cnt <= 0;
      end else if (!stall) begin
         m    <= model_next();
         prev <= m;
         if (model_haz() && !flush && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ex_valid",    ex_valid,    m.valid);
         chk("ex_regwrite", ex_regwrite, m.regwrite);
         chk("ex_memread",  ex_memread,  m.memread);
         chk("ex_memwrite", ex_memwrite, m.memwrite);
         chk("ex_memtoreg", ex_memtoreg, m.memtoreg);
         chk("ex_alusrc",   ex_alusrc,   m.alusrc);
         chk("ex_aluop",    ex_aluop,    m.aluop);
         chk("forwardA",    forwardA,    m.fa);
         chk("forwardB",    forwardB,    m.fb);
         chk("MEMforwardA", MEMforwardA, m.mfa);
         chk("MEMforwardB", MEMforwardB, m.mfb);
         chk("hazard_stall", hazard_stall, model_haz());
         chk("stall_count", stall_count, m_cnt);
         if (!m.dc) begin
            chk("ex_rs",     ex_rs,     m.rs);
            chk("ex_rt",     ex_rt,     m.rt);
            chk("ex_rd",     ex_rd,     m.rd);
            chk("ex_rsdata", ex_rsdata, m.rsd);
            chk("ex_rtdata", ex_rtdata, m.rtd);
            chk("ex_imm",    ex_imm,    m.imm);
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // EX/MEM inputs track the instruction that left EX, as a real pipe would.
   task automatic follow();
      exmem_regwrite = prev.valid && prev.regwrite;
      exmem_rd       = prev.rd;
   endtask

   task automatic issue(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input bit rw, input bit mr,
                        input logic [3:0] op);
      #1;
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_regwrite = rw; id_memread = mr; id_memwrite = 1'b0;
      id_memtoreg = mr; id_alusrc = mr; id_aluop = op;
      id_rsdata = $urandom; id_rtdata = $urandom; id_imm = $urandom;
      follow();
   endtask

   task automatic rand_in();
      #1;
      rst       = ($urandom_range(99) < 2);
      stall     = ($urandom_range(99) < 10);
      flush     = ($urandom_range(99) < 10);
      id_valid  = ($urandom_range(99) < 85);
      id_rs = 5'($urandom_range(3)); id_rt = 5'($urandom_range(3)); id_rd = 5'($urandom_range(3));
      id_regwrite = 1'($urandom); id_memread = ($urandom_range(99) < 35);
      id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom); id_alusrc = 1'($urandom);
      id_aluop = 4'($urandom);
      id_rsdata = $urandom; id_rtdata = $urandom; id_imm = $urandom;
      if ($urandom_range(1) == 0) follow();
      else begin
         exmem_regwrite = 1'($urandom);
         exmem_rd       = 5'($urandom_range(3));
      end
   endtask

   task automatic load_use_pair();
      issue(1, 5'd1, 5'd0, 5'd8, 1, 1, 4'd0);
      step();
      issue(1, 5'd8, 5'd8, 5'd9, 1, 0, 4'd1);
      step();                 // bubble
      #1 follow();
      step();                 // add enters EX
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_rsdata = '0; id_rtdata = '0; id_imm = '0;
      id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
      id_memtoreg = 1'b0; id_alusrc = 1'b0; id_aluop = '0;
      exmem_regwrite = 1'b0; exmem_rd = '0;
      step(); step();
      chk_en = 1'b1;
      chk("rst_valid", ex_valid, 0);
      chk("rst_count", stall_count, 0);

      // hazard is 0 straight after reset even with a reader in ID
      issue(1, 5'd8, 5'd8, 5'd9, 1, 0, 4'd1);
      #1 chk("haz_after_rst", hazard_stall, 0);
      step();

      // add r3,r1,r2 ; sub r5,r3,r4
      issue(1, 5'd1, 5'd2, 5'd3, 1, 0, 4'd1); step();
      issue(1, 5'd3, 5'd4, 5'd5, 1, 0, 4'd2); step();
      chk("b2b_fA", forwardA, 3'b010);
      chk("b2b_mfA", MEMforwardA, 3'b000);
      chk("b2b_fB", forwardB, 3'b000);

      // add r3 ; unrelated ; or r6,r7,r3
      issue(1, 5'd1, 5'd2, 5'd3, 1, 0, 4'd1); step();
      issue(1, 5'd10, 5'd11, 5'd12, 1, 0, 4'd1); step();
      issue(1, 5'd7, 5'd3, 5'd6, 1, 0, 4'd3); step();
      chk("d2_fB", forwardB, 3'b000);
      chk("d2_mfB", MEMforwardB, 3'b001);

      // lw r8 ; add r9,r8,r8 from a fresh reset
      #1 rst = 1'b1; step();
      issue(1, 5'd1, 5'd0, 5'd8, 1, 1, 4'd0); step();
      issue(1, 5'd8, 5'd8, 5'd9, 1, 0, 4'd1);
      #1 chk("lu_haz", hazard_stall, 1);
      step();
      chk("lu_bubble", ex_valid, 0);
      chk("lu_cnt", stall_count, 1);
      #1 follow();
      #1 chk("lu_haz_once", hazard_stall, 0);
      step();
      chk("lu_valid", ex_valid, 1);
      chk("lu_mfA", MEMforwardA, 3'b001);
      chk("lu_mfB", MEMforwardB, 3'b001);
      chk("lu_fA", forwardA, 3'b000);

      // two producers of r3
      issue(1, 5'd1, 5'd2, 5'd3, 1, 0, 4'd1); step();
      issue(1, 5'd4, 5'd5, 5'd3, 1, 0, 4'd1); step();
      issue(1, 5'd3, 5'd0, 5'd7, 1, 0, 4'd1); step();
      chk("dp_fA", forwardA, 3'b010);
      chk("dp_mfA", MEMforwardA, 3'b000);

      // register 0 never forwards
      issue(1, 5'd1, 5'd2, 5'd0, 1, 0, 4'd1); step();
      issue(1, 5'd0, 5'd0, 5'd4, 1, 0, 4'd1);
      exmem_regwrite = 1'b1; exmem_rd = 5'd0;
      step();
      chk("r0_fA", forwardA, 0);  chk("r0_fB", forwardB, 0);
      chk("r0_mfA", MEMforwardA, 0); chk("r0_mfB", MEMforwardB, 0);

      // flush coinciding with load-use: one bubble, count unchanged
      issue(1, 5'd1, 5'd0, 5'd8, 1, 1, 4'd0); step();
      issue(1, 5'd8, 5'd8, 5'd9, 1, 0, 4'd1);
      flush = 1'b1;
      #1 chk("fl_haz", hazard_stall, 1);
      step();
      chk("fl_bubble", ex_valid, 0);
      chk("fl_cnt", stall_count, 1);

      // three stalled cycles with churning inputs hold EX
      issue(1, 5'd1, 5'd2, 5'd3, 1, 0, 4'd1); step();
      issue(1, 5'd3, 5'd3, 5'd5, 1, 0, 4'd4); step();
      for (int i = 0; i < 3; i++) begin
         rand_in();
         rst = 1'b0; stall = 1'b1;
         step();
         chk("hold_fA", forwardA, 3'b010);
         chk("hold_fB", forwardB, 3'b010);
         chk("hold_rd", ex_rd, 5'd5);
         chk("hold_op", ex_aluop, 4'd4);
      end

      // reset overrides stall
      #1 stall = 1'b1; rst = 1'b1;
      step();
      chk("rs_valid", ex_valid, 0);
      chk("rs_fA", forwardA, 0);
      chk("rs_rd", ex_rd, 0);
      chk("rs_data", ex_rsdata, 0);
      chk("rs_cnt", stall_count, 0);

      // counter saturates
      for (int i = 0; i < int'(CMAX); i++) load_use_pair();
      chk("sat_full", stall_count, CMAX);
      load_use_pair();
      chk("sat_hold", stall_count, CMAX);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rand_in();
         step();
      end

      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data path width.
REQ-002 The block SHALL have parameter CW, default 16, meaning the width of the stall-event counter.
REQ-003 clk  in  1  the only clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  global pipeline freeze; holds all state.
REQ-006 flush  in  1  branch/jump squash of the instruction currently in ID.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs, id_rt, id_rd  in  5 each  source and destination register numbers; id_rd is already muxed by regdst.
REQ-009 id_rsdata, id_rtdata, id_imm  in  DW each  operands and the sign-extended immediate.
REQ-010 id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc  in  1 each  control bits.
REQ-011 id_aluop  in  4  ALU operation.
REQ-012 exmem_regwrite  in  1 and exmem_rd  in  5  destination of the instruction currently in EX/MEM.
REQ-013 ex_* outputs  out  registered copies of every id_* input above, plus ex_valid.
REQ-014 forwardA, forwardB  out  3 each  EX-result select codes.
REQ-015 MEMforwardA, MEMforwardB  out  3 each  MEM/WB-result select codes.
REQ-016 hazard_stall  out  1  load-use stall request to PC and IF/ID; combinational.
REQ-017 stall_count  out  CW  count of inserted bubbles.

Function
REQ-018 Forward code 3'b010 SHALL mean "take EX/MEM aluresult"; 3'b001 SHALL mean "take MEM/WB write data"; 3'b000 SHALL mean "use register-file data".
REQ-019 hazard_stall SHALL be 1 when ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt) & id_valid; otherwise it SHALL be 0.
REQ-020 Priority per cycle SHALL be rst > stall > flush > hazard_stall > normal load.
REQ-021 When stall=1, every register, including the forward codes and stall_count, SHALL hold its value.
REQ-022 When flush=1 or hazard_stall=1 (with stall=0), the register SHALL load a bubble: ex_valid=0, all control bits 0, ex_aluop=0, all forward codes 3'b000; data fields don't-care.
REQ-023 On normal load, the register SHALL capture every id_* field, with ex_valid=id_valid, one cycle latency.
REQ-024 Forward codes SHALL be computed from the ID instruction at load time and registered, so they are valid for the whole EX cycle.
REQ-025 forwardA SHALL load 3'b010 if ex_valid & ex_regwrite & ex_rd!=0 & ex_rd==id_rs; the current EX instruction becomes EX/MEM next cycle.
REQ-026 MEMforwardA SHALL load 3'b001 if exmem_regwrite & exmem_rd!=0 & exmem_rd==id_rs and the REQ-025 condition is false; the newest producer wins and the codes are never both non-zero.
REQ-027 forwardB and MEMforwardB SHALL follow REQ-025 and REQ-026 with id_rt in place of id_rs.
REQ-028 Register 0 SHALL never produce a non-zero forward code.
REQ-029 stall_count SHALL increment by 1 on each cycle a hazard_stall bubble is loaded, and SHALL saturate at all-ones.
REQ-030 Flush bubbles SHALL NOT increment stall_count.
REQ-031 When flush and hazard_stall are both 1, a single bubble SHALL be loaded and stall_count SHALL NOT increment.

Reset
REQ-032 When rst=1 at a clock edge, ex_valid, all control outputs, all forward codes, and stall_count SHALL become 0; all data outputs SHALL become 0.
REQ-033 A reset applied mid-stall SHALL override stall.
REQ-034 hazard_stall SHALL read 0 in the cycle after reset, because ex_valid=0.

Verification
REQ-035 Back-to-back ALU dependence: "add r3,r1,r2" then "sub r5,r3,r4" -> in the sub's EX cycle forwardA=3'b010, MEMforwardA=3'b000, forwardB=3'b000.
REQ-036 Distance-2 dependence: add r3, then unrelated, then "or r6,r7,r3" -> forwardB=3'b000, MEMforwardB=3'b001.
REQ-037 Load-use: "lw r8,0(r1)" then "add r9,r8,r8" -> hazard_stall=1 for exactly one cycle; a bubble with ex_valid=0 enters EX; stall_count 0->1. Next cycle the add loads with MEMforwardA=MEMforwardB=3'b001.
REQ-038 Double producer: EX holds a write to r3 and EX/MEM holds a write to r3; ID reads r3 -> forwardA=3'b010 and MEMforwardA=3'b000.
REQ-039 Register-0 and flush case: ID reads r0 while EX writes r0 -> all codes 3'b000. With flush=1 and a load-use condition in the same cycle -> one bubble and stall_count unchanged.
REQ-040 Stall hold and reset: stall=1 for 3 cycles holds all outputs bit-exact. With stall_count preset to 0xFFFF, a further load-use keeps it at 0xFFFF. rst asserted during stall -> all outputs 0 next edge.
